hps_key_pio: RTL and testbench

Avalon-MM slave input PIO: the input-direction counterpart of the HPS LED output PIO. It samples `WIDTH` asynchronous board inputs (push-buttons/switches) through a synchronizer, detects edges into a sticky capture register, and raises a level interrupt to the HPS when a captured edge is unmasked. It sits on the HPS lightweight bridge next to the LED PIO and uses the same 2-bit word address map.

---
 rtl/hps_pio_pkg.sv | 15 +
 rtl/hps_pio_in_filter.sv | 53 +++++
 rtl/hps_key_pio.sv | 93 +++++++++
 tb/tb_hps_key_pio.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/hps_pio_pkg.sv
// Shared constants for the HPS lightweight-bridge PIO blocks: word address map and edge-type selection.
package hps_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  typedef enum int {
    EDGE_RISE = 0,
    EDGE_FALL = 1,
    EDGE_ANY  = 2
  } edge_type_e;

endpackage

// File: rtl/hps_pio_in_filter.sv
// One input bit: reset-to-idle synchronizer, followed by an optional stable-count debouncer
// (enabled by HPS_KEY_PIO_DEBOUNCE_EN).
module hps_pio_in_filter #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter logic        IDLE_LEVEL      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic f
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= {SYNC_STAGES{IDLE_LEVEL}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in_bit};
    end
  end

  assign s = sync[SYNC_STAGES-1];

`ifdef HPS_KEY_PIO_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             f_q;

  // The output flips on the DEBOUNCE_CYCLES-th consecutive cycle of disagreement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      f_q <= IDLE_LEVEL;
    end else if (s == f_q) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt <= '0;
      f_q <= s;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign f = f_q;
`else
  assign f = s;
`endif

endmodule

// File: rtl/hps_key_pio.sv
// Avalon-MM input PIO for board keys/switches: synchronized DATA, sticky EDGECAP, IRQMASK, level irq.
// Optional per-bit debounce is built when HPS_KEY_PIO_DEBOUNCE_EN is defined.
module hps_key_pio
  import hps_pio_pkg::*;
#(
  parameter int unsigned      WIDTH           = 4,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = '1,
  parameter int unsigned      SYNC_STAGES     = 2,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] f_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] clr;
  logic             wr;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_filt
    hps_pio_in_filter #(
      .SYNC_STAGES    (SYNC_STAGES),
      .IDLE_LEVEL     (IDLE_LEVEL[i]),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filt (
      .clk    (clk),
      .reset_n(reset_n),
      .in_bit (in_port[i]),
      .f      (f[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_d <= IDLE_LEVEL;
    end else begin
      f_d <= f;
    end
  end

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_det = f & ~f_d;
      EDGE_FALL: edge_det = ~f & f_d;
      EDGE_ANY:  edge_det = f ^ f_d;
      default:   edge_det = '0;
    endcase
  end

  assign wr           = chipselect && !write_n;
  assign clr          = (wr && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  // A new edge on a bit overrides a simultaneous write-1-to-clear of that bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
      edgecap <= '0;
    end else begin
      if (wr && address == PIO_ADDR_IRQMASK) begin
        irqmask <= writedata[WIDTH-1:0];
      end
      edgecap <= (edgecap & ~clr) | edge_det;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      PIO_ADDR_DATA:    readdata = 32'(f);
      PIO_ADDR_RSVD:    readdata = '0;
      PIO_ADDR_IRQMASK: readdata = 32'(irqmask);
      PIO_ADDR_EDGECAP: readdata = 32'(edgecap);
      default:          readdata = '0;
    endcase
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_hps_key_pio.sv
// Directed bench for hps_key_pio in the default (no debounce) build, falling-edge capture, 4 bits.
module tb_hps_key_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hps_key_pio #(
    .WIDTH          (4),
    .EDGE_TYPE      (1),
    .IDLE_LEVEL     (4'hF),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(50000)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns past the next rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;
    tick(3);
    reset_n = 1'b1;

    // Reset state
    check("rst_irq", 32'(irq), 32'd0);
    rd(2'd0, 32'hF, "rst_data");
    rd(2'd1, 32'h0, "rst_rsvd");
    rd(2'd2, 32'h0, "rst_mask");
    rd(2'd3, 32'h0, "rst_edgecap");
    tick(20);
    rd(2'd3, 32'h0, "idle_edgecap_20cyc");

    // Falling edge on bit1, masked in
    wr(2'd2, 32'h2);
    rd(2'd2, 32'h2, "mask_rb");
    check("mask_only_irq", 32'(irq), 32'd0);
    in_port = 4'hD;
    tick();
    rd(2'd0, 32'hF, "data_edge1");
    tick();
    rd(2'd0, 32'hD, "data_edge2");
    rd(2'd3, 32'h0, "edgecap_edge2");
    check("irq_edge2", 32'(irq), 32'd0);
    tick();
    rd(2'd3, 32'h2, "edgecap_edge3");
    check("irq_edge3", 32'(irq), 32'd1);
    wr(2'd3, 32'h2);
    rd(2'd3, 32'h0, "edgecap_cleared");
    check("irq_cleared", 32'(irq), 32'd0);

    // Masking: edges on bits 0 and 3 with mask 0
    wr(2'd2, 32'h0);
    in_port = 4'h4;
    tick(3);
    rd(2'd0, 32'h4, "data_b03_low");
    rd(2'd3, 32'h9, "edgecap_b03");
    check("irq_unmasked_none", 32'(irq), 32'd0);
    wr(2'd2, 32'h8);
    check("irq_mask8", 32'(irq), 32'd1);
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h8, "edgecap_clr_b0");
    check("irq_still_b3", 32'(irq), 32'd1);

    // Rising edges are not captured in falling mode
    in_port = 4'hF;
    tick(3);
    rd(2'd0, 32'hF, "data_all_high");
    rd(2'd3, 32'h8, "edgecap_no_rise");

    // Collision: falling edge on bit2 lands on the same edge as its clear
    in_port = 4'hB;
    tick(2);
    wr(2'd3, 32'h4);
    rd(2'd3, 32'hC, "edgecap_collision");
    wr(2'd3, 32'h4);
    rd(2'd3, 32'h8, "edgecap_b2_clr");

    // Writes to reserved address are ignored
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, 32'h0, "rsvd_after_wr");
    rd(2'd2, 32'h8, "mask_after_rsvd_wr");

    // Reset mid-operation
    in_port = 4'hF;
    tick(3);
    in_port = 4'h0;
    tick(3);
    rd(2'd3, 32'hF, "edgecap_all");
    wr(2'd2, 32'hF);
    check("irq_all", 32'(irq), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_irq", 32'(irq), 32'd0);
    rd(2'd0, 32'hF, "async_rst_data");
    rd(2'd2, 32'h0, "async_rst_mask");
    rd(2'd3, 32'h0, "async_rst_edgecap");
    in_port = 4'hF;
    reset_n = 1'b1;
    tick(4);
    rd(2'd3, 32'h0, "post_rst_edgecap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
